dds_asf_writer: RTL
===================

// Module: dds_asf_writer
// PURPOSE
// Serial writer for the AD9954 amplitude scale factor (ASF) register. Sits directly downstream of manual_amp.
// - Watches the 14-bit ampDDS word.
// - On any change, writes ASF register 0x02 over the 3-wire serial port (SCLK/SDIO/CS_N).
// - Then pulses IO_UPDATE so the new amplitude takes effect.
// - Also writes the current value once after reset, so the DDS always matches the front-panel state.
// PARAMETERS
// CLK_DIV    4      clk cycles per SCLK half-period (>=1)
// ASF_ADDR   5'h02  AD9954 register address written
// RAMP_RATE  2'b00  value placed in ASF[15:14] (auto-ramp rate speed control)
// UPD_WIDTH  4      IO_UPDATE high time in clk cycles (>=1)
// PORTS
// clk        in   1   system clock
// rst_n      in   1   asynchronous active-low reset
// ampDDS     in   14  amplitude word from manual_amp (binary, 0..16383)
// force_wr   in   1   single-cycle request to rewrite ampDDS even if unchanged
// dds_sclk   out  1   serial clock to AD9954 (idle low)
// dds_sdio   out  1   serial data to AD9954, MSB first
// dds_cs_n   out  1   chip select, active low
// dds_ioupd  out  1   IO_UPDATE strobe
// busy       out  1   high from frame start through end of IO_UPDATE pulse
// done       out  1   1-cycle pulse after each completed write
// BEHAVIOUR
// Reset (async, rst_n=0):
// - sclk=0, sdio=0, cs_n=1, ioupd=0, busy=0, done=0.
// - last_sent=14'h0000, pending=1, state=IDLE.
// Pending flag:
// - Set every cycle where ampDDS!=last_sent, or force_wr=1.
// - Cleared only in the LOAD cycle. A set on the same cycle as LOAD wins, so the request is kept.
// Frame (24 bits, MSB first):
// - {1'b0 (write), 2'b00, ASF_ADDR[4:0], RAMP_RATE[1:0], amp[13:0]}.
// - amp is sampled once, in LOAD. It is also copied to last_sent in LOAD.
// States:
// - IDLE: busy=0. If pending -> LOAD.
// - LOAD (1 cycle): latch frame, cs_n<=0, sdio<=frame[23], sclk=0, busy<=1, bit count=0 -> SHIFT.
// - SHIFT: SCLK runs low CLK_DIV cycles, then high CLK_DIV cycles, per bit.
//   - AD9954 samples on SCLK rise. sdio changes only on SCLK fall.
//   - On each fall after bits 0..22, shift out the next bit.
//   - After the 24th high phase: sclk<=0 -> TAIL.
// - TAIL: CLK_DIV cycles with sclk=0, cs_n still low. Then cs_n<=1, sdio<=0 -> GAP.
// - GAP: CLK_DIV cycles with cs_n=1 -> UPD.
// - UPD: ioupd=1 for exactly UPD_WIDTH cycles -> DONE.
// - DONE (1 cycle): ioupd=0, done=1, busy<=0 -> IDLE.
//   - If pending is already set, the next LOAD follows in the immediately next cycle.
// Timing:
// - cs_n low from LOAD+1 for exactly 49*CLK_DIV cycles.
// - First SCLK rise at LOAD+1+CLK_DIV.
// - SCLK rise spacing is 2*CLK_DIV.
// Changes while busy:
// - Never corrupt the current frame.
// - Any number of changes during a frame collapse into one follow-up write of the value present at the next LOAD.
// Reset mid-frame:
// - Outputs return to reset values immediately (cs_n=1 asynchronously).
// - The aborted frame is discarded. After release, a full write of the current ampDDS occurs (pending=1).
// Hold rules:
// - No SCLK edges while cs_n=1.
// - ioupd never overlaps cs_n=0.
// TESTING
// 1. Release reset with ampDDS=0, CLK_DIV=4 -> one frame 0x020000; cs_n low 196 cycles; ioupd 4 cycles; done pulse; then idle.
// 2. ampDDS 0->163 while idle -> frame 0x0200A3 sampled on SCLK rises; ioupd after cs_n high 4 cycles; last_sent=163.
// 3. ampDDS 163->326 during bit 10 of a frame -> current frame completes with 0x00A3; next LOAD the cycle after done; frame 0x020146.
// 4. Three changes (326, 489, 652) within one frame -> exactly one follow-up frame carrying 0x028C (652); no extra writes.
// 5. Pulse rst_n low at bit 12 -> cs_n=1, sclk=0 same cycle; after release a complete frame of the current ampDDS; no partial IO_UPDATE.
// 6. CLK_DIV=1, force_wr with ampDDS=16300 (0x3FAC) -> frame 0x023FAC; 24 rises 2 cycles apart; cs_n low 49 cycles.

Source files
------------

// File: rtl/dds_asf_writer.sv
// Serial writer for the AD9954 amplitude scale factor register.
// Rewrites ASF over the 3-wire port and strobes IO_UPDATE whenever ampDDS changes, on request, or after reset.
module dds_asf_writer #(
    parameter int         CLK_DIV   = 4,
    parameter logic [4:0] ASF_ADDR  = 5'h02,
    parameter logic [1:0] RAMP_RATE = 2'b00,
    parameter int         UPD_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] ampDDS,
    input  logic        force_wr,
    output logic        dds_sclk,
    output logic        dds_sdio,
    output logic        dds_cs_n,
    output logic        dds_ioupd,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] UPD_LAST = 16'(UPD_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, TAIL, GAP, UPD, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [4:0]  bit_cnt, bit_cnt_nxt;
    logic [22:0] shreg, shreg_nxt;
    logic [13:0] last_sent, last_sent_nxt;
    logic        pending, pending_nxt;
    logic        sclk_nxt, sdio_nxt, cs_n_nxt, ioupd_nxt, busy_nxt, done_nxt;
    logic [23:0] frame;

    assign frame = {1'b0, 2'b00, ASF_ADDR, RAMP_RATE, ampDDS};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            last_sent <= '0;
            pending   <= 1'b1;
            dds_sclk  <= 1'b0;
            dds_sdio  <= 1'b0;
            dds_cs_n  <= 1'b1;
            dds_ioupd <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            last_sent <= last_sent_nxt;
            pending   <= pending_nxt;
            dds_sclk  <= sclk_nxt;
            dds_sdio  <= sdio_nxt;
            dds_cs_n  <= cs_n_nxt;
            dds_ioupd <= ioupd_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        last_sent_nxt = last_sent;
        pending_nxt   = pending;
        sclk_nxt      = dds_sclk;
        sdio_nxt      = dds_sdio;
        cs_n_nxt      = dds_cs_n;
        ioupd_nxt     = dds_ioupd;
        busy_nxt      = busy;
        done_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (pending) state_nxt = LOAD;
            end
            LOAD: begin
                shreg_nxt     = frame[22:0];
                sdio_nxt      = frame[23];
                cs_n_nxt      = 1'b0;
                sclk_nxt      = 1'b0;
                busy_nxt      = 1'b1;
                bit_cnt_nxt   = '0;
                cnt_nxt       = '0;
                last_sent_nxt = ampDDS;
                pending_nxt   = 1'b0;
                state_nxt     = SHIFT;
            end
            SHIFT: begin
                // Data only moves on the falling edge so the DDS always samples a settled bit.
                if (cnt == DIV_LAST) begin
                    cnt_nxt = '0;
                    if (!dds_sclk) begin
                        sclk_nxt = 1'b1;
                    end else begin
                        sclk_nxt = 1'b0;
                        if (bit_cnt == 5'd23) begin
                            state_nxt = TAIL;
                        end else begin
                            sdio_nxt    = shreg[22];
                            shreg_nxt   = {shreg[21:0], 1'b0};
                            bit_cnt_nxt = bit_cnt + 5'd1;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            TAIL: begin
                if (cnt == DIV_LAST) begin
                    cnt_nxt   = '0;
                    cs_n_nxt  = 1'b1;
                    sdio_nxt  = 1'b0;
                    state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            GAP: begin
                if (cnt == DIV_LAST) begin
                    cnt_nxt   = '0;
                    ioupd_nxt = 1'b1;
                    state_nxt = UPD;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            UPD: begin
                if (cnt == UPD_LAST) begin
                    cnt_nxt   = '0;
                    ioupd_nxt = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = pending ? LOAD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Compare against the post-LOAD value so a word just latched does not request itself again.
        if (force_wr || (ampDDS != last_sent_nxt)) pending_nxt = 1'b1;
    end

endmodule
